fb_if_stage: RTL
================

# fb_if_stage

Instruction-fetch stage of the Firebird pipeline: owns the PC register, fetches instructions from instruction memory over a req/ack handshake, and feeds the fetched instruction back to `fb_ctrl_hazard_unit`. The hazard unit evaluates that instruction within IF. This block applies the resulting next-PC selection, the jalr one-clock lock and misprediction redirects, then loads the IF/ID pipeline register. It sits between instruction memory and the ID stage.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset (word address; PC advances by 1 per instruction).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, held until `imem_ack`.
- `imem_addr` out 32: fetch address, equals PC register, stable while `imem_req`=1.
- `imem_ack` in 1: memory accepted request; `imem_rdata` valid this cycle.
- `imem_rdata` in 32: fetched instruction.
- `cur_pc` out 32: PC of the held instruction, to hazard unit `pc`.
- `cur_inst` out 32: held instruction in S_HOLD, else `FB_NOP_INST` (32'h0000_0013); to hazard unit `inst`.
- `jalr_en` out 1: to hazard unit; high after one lock cycle has elapsed.
- `pc_src` in 1: hazard unit: use `predict_pc`.
- `predict_pc` in 32: predicted next PC.
- `address_src` in 1: hazard unit: misprediction; use `predict_err_pc`.
- `predict_err_pc` in 32: corrected next PC.
- `lock` in 1: hazard unit: jalr lock request.
- `id_ready` in 1: ID stage can accept a new IF/ID entry.
- `ifid_valid` out 1, `ifid_pc` out 32, `ifid_inst` out 32: IF/ID pipeline register.

## Operation
- FSM states: S_RESET, S_REQ, S_HOLD.
- S_RESET: entered on reset; next cycle -> S_REQ. No request issued.
- S_REQ: `imem_req`=1, `imem_addr`=PC. On `imem_ack`: capture `imem_rdata` into inst register, -> S_HOLD. `address_src`, `lock` and `pc_src` are ignored (`cur_inst` is NOP, so the hazard unit produces no branch activity).
- S_HOLD actions, evaluated in priority order:
  1. `address_src`=1: PC <= `predict_err_pc`; `ifid_valid` <= 0 (flush); `jalr_en` <= 0; -> S_REQ.
  2. `lock`=1: stay; `jalr_en` <= 1; IF/ID not written.
  3. `id_ready`=0: stay; all registers hold.
  4. Otherwise (advance): `ifid_pc` <= PC; `ifid_inst` <= inst; `ifid_valid` <= 1; PC <= `pc_src` ? `predict_pc` : PC+1; `jalr_en` <= 0; -> S_REQ.
- IF/ID drain: when `id_ready`=1 and the stage is not advancing this cycle, `ifid_valid` <= 0.
- PC arithmetic is 32-bit modulo: PC 32'hFFFF_FFFF + 1 = 32'h0.
- `imem_ack` outside S_REQ is ignored.

## Timing
- Reset values: PC=`RESET_PC`; state S_RESET; `imem_req`=0; `imem_addr`=`RESET_PC`; inst register=NOP; `cur_inst`=NOP; `jalr_en`=0; `ifid_valid`=0; `ifid_pc`=0; `ifid_inst`=NOP.
- First `imem_req` in the second cycle after `rst_n` deasserts.
- Zero-wait memory (ack in the request cycle): 2 cycles per instruction (S_REQ, S_HOLD). Each memory wait cycle adds 1 cycle.
- jalr: 3 cycles minimum in S_HOLD+REQ, with one extra cycle for the lock. `ifid_*` is updated on the edge that ends the advance cycle.
- Redirect: the wrong-path instruction never reaches IF/ID. The fetch at `predict_err_pc` starts the next cycle.
- `address_src` and `lock` asserted together: redirect wins, and `jalr_en` is cleared.
- Reset asserted mid-request: `imem_req` drops asynchronously and any in-flight ack is discarded.

## Configuration
- `FB_IF_PERF_CNT_EN` defined: adds three 32-bit outputs, reset to 0 and wrapping on overflow:
  - `perf_fetch_cnt`: +1 per advance.
  - `perf_redirect_cnt`: +1 per S_HOLD cycle with `address_src`=1.
  - `perf_lock_cnt`: +1 per S_HOLD cycle with `lock`=1 that does not redirect.
- Undefined: these ports and counters are absent, with no other behavioural difference.

## Structure
- In `fb_defines.v`: `FB_32BITS`, `FB_NOP_INST`, state encodings `FB_IF_S_RESET`/`FB_IF_S_REQ`/`FB_IF_S_HOLD` (2 bits).
- Sub-module `fb_next_pc_mux`: combinational next-PC select implementing S_HOLD priorities 1/4 from `address_src`, `pc_src`, `predict_pc`, `predict_err_pc` and PC.

## Test plan
- Reset with `RESET_PC`=32'h100, zero-wait memory, straight-line code, `id_ready`=1 -> `imem_addr` sequence 100,101,102 every 2 cycles; `ifid_pc` follows with `ifid_valid`=1.
- Memory acks after 3 wait cycles -> `imem_req` and `imem_addr` stay stable for 4 cycles, and no IF/ID write occurs during the wait.
- Held inst is jal with `pc_src`=1, `predict_pc`=32'h200 -> next `imem_addr`=200, and `ifid_inst`=jal with `ifid_pc`=held PC.
- jalr: `lock`=1 for one cycle -> `jalr_en`=1 in the next cycle, then advance to `predict_pc`=32'h340, and `jalr_en` returns to 0.
- Held branch with `address_src`=1, `predict_err_pc`=32'h120 (with `id_ready`=0 as well) -> `ifid_valid`=0, next fetch at 120, no IF/ID write of the branch.
- Assert `rst_n`=0 while `imem_req`=1 and inject `imem_ack` -> all outputs take reset values immediately, and the ack is ignored.

Source files
------------

// File: rtl/fb_if_stage_pkg.sv
// Shared constants, state encoding and IF/ID payload type for the Firebird fetch stage.
package fb_if_stage_pkg;

  localparam int unsigned FB_32BITS = 32;

  localparam logic [FB_32BITS-1:0] FB_NOP_INST = 32'h0000_0013;

  localparam logic [1:0] FB_IF_S_RESET = 2'd0;
  localparam logic [1:0] FB_IF_S_REQ   = 2'd1;
  localparam logic [1:0] FB_IF_S_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    S_RESET = FB_IF_S_RESET,
    S_REQ   = FB_IF_S_REQ,
    S_HOLD  = FB_IF_S_HOLD
  } fb_if_state_e;

  typedef struct packed {
    logic                 valid;
    logic [FB_32BITS-1:0] pc;
    logic [FB_32BITS-1:0] inst;
  } fb_ifid_t;

endpackage

// File: rtl/fb_if_stage_if.sv
// Instruction-memory req/ack fetch bus.
interface fb_if_stage_if;
  import fb_if_stage_pkg::*;

  logic                 req;
  logic [FB_32BITS-1:0] addr;
  logic                 ack;
  logic [FB_32BITS-1:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fb_next_pc_mux.sv
// Next-PC select for S_HOLD: redirect beats prediction, prediction beats sequential.
module fb_next_pc_mux
  import fb_if_stage_pkg::*;
(
  input  logic [FB_32BITS-1:0] pc,
  input  logic                 pc_src,
  input  logic [FB_32BITS-1:0] predict_pc,
  input  logic                 address_src,
  input  logic [FB_32BITS-1:0] predict_err_pc,
  output logic [FB_32BITS-1:0] next_pc_c
);

  // Priority select; PC+1 wraps modulo 2^32.
  always_comb begin
    next_pc_c = pc + 32'd1;
    if (pc_src)      next_pc_c = predict_pc;
    if (address_src) next_pc_c = predict_err_pc;
  end

endmodule

// File: rtl/fb_if_stage.sv
// Firebird IF stage: PC register, imem fetch FSM, jalr lock, redirect and IF/ID register.
// Optional build macro: FB_IF_PERF_CNT_EN adds fetch/redirect/lock event counters.
module fb_if_stage
  import fb_if_stage_pkg::*;
#(
  parameter logic [FB_32BITS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fb_if_stage_if.master        imem,
  output logic [FB_32BITS-1:0] cur_pc,
  output logic [FB_32BITS-1:0] cur_inst,
  output logic                 jalr_en,
  input  logic                 pc_src,
  input  logic [FB_32BITS-1:0] predict_pc,
  input  logic                 address_src,
  input  logic [FB_32BITS-1:0] predict_err_pc,
  input  logic                 lock,
  input  logic                 id_ready,
  output logic                 ifid_valid,
  output logic [FB_32BITS-1:0] ifid_pc,
  output logic [FB_32BITS-1:0] ifid_inst
`ifdef FB_IF_PERF_CNT_EN
  ,
  output logic [FB_32BITS-1:0] perf_fetch_cnt,
  output logic [FB_32BITS-1:0] perf_redirect_cnt,
  output logic [FB_32BITS-1:0] perf_lock_cnt
`endif
);

  fb_if_state_e         state_q;
  logic [FB_32BITS-1:0] pc_q;
  logic [FB_32BITS-1:0] inst_q;
  logic                 req_q;
  logic                 jalr_q;
  fb_ifid_t             ifid_q;
  logic [FB_32BITS-1:0] next_pc_c;
  logic                 in_hold_c;
  logic                 redirect_c;
  logic                 advance_c;

  assign in_hold_c  = (state_q == S_HOLD);
  assign redirect_c = in_hold_c && address_src;
  assign advance_c  = in_hold_c && !address_src && !lock && id_ready;

  fb_next_pc_mux u_next_pc_mux (
    .pc             (pc_q),
    .pc_src         (pc_src),
    .predict_pc     (predict_pc),
    .address_src    (address_src),
    .predict_err_pc (predict_err_pc),
    .next_pc_c      (next_pc_c)
  );

  // Fetch FSM with PC, held instruction, jalr lock flag and IF/ID register.
  // inst_q is cleared to NOP whenever S_HOLD is left, so it doubles as cur_inst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      inst_q  <= FB_NOP_INST;
      req_q   <= 1'b0;
      jalr_q  <= 1'b0;
      ifid_q  <= '{valid: 1'b0, pc: '0, inst: FB_NOP_INST};
    end else begin
      case (state_q)
        S_RESET: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (imem.ack) begin
            inst_q  <= imem.rdata;
            req_q   <= 1'b0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (address_src) begin
            pc_q    <= next_pc_c;
            inst_q  <= FB_NOP_INST;
            jalr_q  <= 1'b0;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end else if (lock) begin
            jalr_q <= 1'b1;
          end else if (id_ready) begin
            ifid_q  <= '{valid: 1'b1, pc: pc_q, inst: inst_q};
            pc_q    <= next_pc_c;
            inst_q  <= FB_NOP_INST;
            jalr_q  <= 1'b0;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_RESET;
          req_q   <= 1'b0;
        end
      endcase
      // Flush on redirect; drain a consumed entry when nothing new is written.
      if (redirect_c || (id_ready && !advance_c)) begin
        ifid_q.valid <= 1'b0;
      end
    end
  end

  assign imem.req   = req_q;
  assign imem.addr  = pc_q;
  assign cur_pc     = pc_q;
  assign cur_inst   = inst_q;
  assign jalr_en    = jalr_q;
  assign ifid_valid = ifid_q.valid;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_inst  = ifid_q.inst;

`ifdef FB_IF_PERF_CNT_EN
  // Free-running wrapping event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
      perf_lock_cnt     <= '0;
    end else begin
      if (advance_c)                        perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
      if (redirect_c)                       perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      if (in_hold_c && lock && !address_src) perf_lock_cnt    <= perf_lock_cnt + 32'd1;
    end
  end
`endif

endmodule
